// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared CPU pipeline types for hazard control
package hazard_ctrl_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: ALU operand forwarding select for one source register
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] fwd
);
  // MEM result is newer than WB, so it wins; x0 is never forwarded
  always_comb
    fwd = (regWriteM && rdM != 5'd0 && rdM == rs) ? FWD_MEM :
          (regWriteW && rdW != 5'd0 && rdW == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with memory-wait tracking
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memReadE,
  input  logic             pcSrcE,
  input  logic             memReqM,
  input  logic             memReadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);
  localparam int WC_W = $clog2(WAIT_LIMIT + 1);
  state_t state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic load_use, mem_stall, flush_sel, any_stall, timeout_hit;

  fwd_sel u_fwd_a (.rs(rs1E), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW), .fwd(forwardAE));
  fwd_sel u_fwd_b (.rs(rs2E), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW), .fwd(forwardBE));

  // Priority: memory stall freezes everything, then branch redirect, then load-use bubble
  always_comb begin
    load_use  = memReadE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
    mem_stall = memReqM && !memReadyM;
    flush_sel = !mem_stall && pcSrcE;
    stallF    = mem_stall || (!pcSrcE && load_use);
    stallD    = mem_stall || (!pcSrcE && load_use);
    stallE    = mem_stall;
    stallM    = mem_stall;
    flushD    = flush_sel;
    flushE    = !mem_stall && (pcSrcE || load_use);
    any_stall = stallF || stallD || stallE || stallM;
  end

  // WAIT tracks an outstanding memory stall; the counter restarts on entry and saturates
  always_comb begin
    state_nxt   = mem_stall ? WAIT : IDLE;
    wait_nxt    = (state == IDLE) ? '0 :
                  (mem_stall && wait_cnt != WC_W'(WAIT_LIMIT)) ? wait_cnt + 1'b1 : wait_cnt;
    timeout_hit = mem_stall && wait_nxt == WC_W'(WAIT_LIMIT - 1);
  end

  // State, wait counter, sticky timeout and saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      memTimeout  <= 1'b0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      memTimeout <= memTimeout || timeout_hit;
      if (any_stall && !(&stallCycles)) stallCycles <= stallCycles + 1'b1;
      if (flush_sel && !(&flushCount)) flushCount <= flushCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [5:0] ctl;
    logic [3:0] stl;
    logic [1:0] fl, fa, fb;
  } vec_t;

  logic clk, rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regWriteM, regWriteW, memReadE, pcSrcE, memReqM, memReadyM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, memTimeout;
  logic [1:0] forwardAE, forwardBE;
  logic [3:0] stallCycles, flushCount;
  int checks = 0;
  int errors = 0;
  vec_t tbl[15];

  hazard_ctrl #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memReadE(memReadE), .pcSrcE(pcSrcE), .memReqM(memReqM), .memReadyM(memReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .memTimeout(memTimeout), .stallCycles(stallCycles), .flushCount(flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int a, int b, int c, int d, int e, int f, int g,
                              logic [5:0] ctl, logic [3:0] stl, logic [1:0] fl, logic [1:0] fa, logic [1:0] fb);
    vec_t v;
    v.rs1D = 5'(a); v.rs2D = 5'(b); v.rs1E = 5'(c); v.rs2E = 5'(d);
    v.rdE = 5'(e); v.rdM = 5'(f); v.rdW = 5'(g);
    v.ctl = ctl; v.stl = stl; v.fl = fl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
    rdE = v.rdE; rdM = v.rdM; rdW = v.rdW;
    {regWriteM, regWriteW, memReadE, pcSrcE, memReqM, memReadyM} = v.ctl;
  endtask

  task automatic idle();
    drive('0);
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #2;
    chk("rst state", 32'(dut.state), 32'(IDLE));
    chk("rst timeout", 32'(memTimeout), 32'd0);
    chk("rst stallCycles", 32'(stallCycles), 32'd0);
    chk("rst flushCount", 32'(flushCount), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // ctl = {regWriteM, regWriteW, memReadE, pcSrcE, memReqM, memReadyM}; stl = {F,D,E,M}; fl = {D,E}
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b110000, 4'b0000, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(0, 0, 5, 0, 0, 5, 5, 6'b110000, 4'b0000, 2'b00, 2'b10, 2'b00);
    tbl[2]  = mk(0, 0, 5, 0, 0, 5, 5, 6'b010000, 4'b0000, 2'b00, 2'b01, 2'b00);
    tbl[3]  = mk(0, 0, 5, 0, 0, 0, 0, 6'b110000, 4'b0000, 2'b00, 2'b00, 2'b00);
    tbl[4]  = mk(0, 0, 9, 7, 0, 7, 9, 6'b110000, 4'b0000, 2'b00, 2'b01, 2'b10);
    tbl[5]  = mk(0, 0, 1, 9, 0, 4, 9, 6'b110000, 4'b0000, 2'b00, 2'b00, 2'b01);
    tbl[6]  = mk(0, 3, 0, 0, 3, 0, 0, 6'b001000, 4'b1100, 2'b01, 2'b00, 2'b00);
    tbl[7]  = mk(3, 0, 0, 0, 3, 0, 0, 6'b001000, 4'b1100, 2'b01, 2'b00, 2'b00);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b001000, 4'b0000, 2'b00, 2'b00, 2'b00);
    tbl[9]  = mk(3, 0, 0, 0, 3, 0, 0, 6'b000000, 4'b0000, 2'b00, 2'b00, 2'b00);
    tbl[10] = mk(0, 3, 0, 0, 3, 0, 0, 6'b001100, 4'b0000, 2'b11, 2'b00, 2'b00);
    tbl[11] = mk(0, 3, 0, 0, 3, 0, 0, 6'b001110, 4'b1111, 2'b00, 2'b00, 2'b00);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 6'b000111, 4'b0000, 2'b11, 2'b00, 2'b00);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 6'b000010, 4'b1111, 2'b00, 2'b00, 2'b00);
    tbl[14] = mk(0, 0, 6, 6, 0, 6, 6, 6'b110000, 4'b0000, 2'b00, 2'b10, 2'b10);

    rst = 1'b1;
    idle();
    #1 rst_pulse();

    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      #2;
      chk($sformatf("v%0d stall", i), 32'({stallF, stallD, stallE, stallM}), 32'(tbl[i].stl));
      chk($sformatf("v%0d flush", i), 32'({flushD, flushE}), 32'(tbl[i].fl));
      chk($sformatf("v%0d fwdA", i), 32'(forwardAE), 32'(tbl[i].fa));
      chk($sformatf("v%0d fwdB", i), 32'(forwardBE), 32'(tbl[i].fb));
    end

    @(posedge clk);
    #1 idle();
    rst_pulse();

    drive(tbl[6]);
    #2 chk("lu stalls", 32'({stallF, stallD, flushE}), 32'b111);
    @(posedge clk);
    #1 idle();
    chk("lu stallCycles", 32'(stallCycles), 32'd1);
    chk("lu flushCount", 32'(flushCount), 32'd0);
    #2 chk("lu one cycle", 32'(stallF), 32'd0);
    @(posedge clk);
    #1 chk("lu stallCycles hold", 32'(stallCycles), 32'd1);

    drive(tbl[10]);
    #2 chk("br flush", 32'({flushD, flushE, stallF}), 32'b110);
    @(posedge clk);
    #1 idle();
    chk("br flushCount", 32'(flushCount), 32'd1);
    chk("br stallCycles", 32'(stallCycles), 32'd1);

    memReqM = 1'b1;
    memReadyM = 1'b0;
    pcSrcE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("mw%0d stalls", k), 32'({stallF, stallD, stallE, stallM}), 32'hf);
      chk($sformatf("mw%0d flush", k), 32'({flushD, flushE}), 32'd0);
      @(posedge clk);
      #1 chk($sformatf("mw%0d state", k), 32'(dut.state), 32'(WAIT));
    end
    chk("mw stallCycles", 32'(stallCycles), 32'd4);
    chk("mw flushCount", 32'(flushCount), 32'd1);
    memReadyM = 1'b1;
    #2;
    chk("mw release flush", 32'({flushD, flushE}), 32'b11);
    chk("mw release stalls", 32'({stallF, stallD, stallE, stallM}), 32'd0);
    @(posedge clk);
    #1 idle();
    chk("mw idle", 32'(dut.state), 32'(IDLE));
    chk("mw flushCount after", 32'(flushCount), 32'd2);
    chk("mw no timeout", 32'(memTimeout), 32'd0);

    rst_pulse();
    memReqM = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1 chk($sformatf("to cycle%0d", k), 32'(memTimeout), (k >= 4) ? 32'd1 : 32'd0);
    end
    chk("to stallCycles", 32'(stallCycles), 32'd6);
    chk("to state", 32'(dut.state), 32'(WAIT));
    rst_pulse();
    @(posedge clk);
    #1 chk("resume stallCycles", 32'(stallCycles), 32'd1);
    chk("resume timeout", 32'(memTimeout), 32'd0);
    repeat (20) @(posedge clk);
    #1 chk("sat stallCycles", 32'(stallCycles), 32'd15);
    chk("sat timeout", 32'(memTimeout), 32'd1);

    idle();
    rst_pulse();
    pcSrcE = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("sat flushCount", 32'(flushCount), 32'd15);
    chk("sat no stall", 32'(stallCycles), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
